// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-line instruction cache between IF and the memory controller
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic [31:0] inst_out,
    output logic        inst_valid_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cancel;
    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [31:0]         r_data [LINES];
    logic [31:0]         r_inst;
    logic                r_inst_valid;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;

    logic [INDEX_BITS-1:0] w_lu_idx;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_BITS-1:0]   w_lu_tag;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_lu_io;
    logic                  w_fill_io;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_unused;

    logic                  w_cancel_nxt;
    logic                  w_valid_nxt;
    logic [31:0]           w_inst_nxt;
    logic                  w_mem_req_nxt;
    logic [31:0]           w_mem_addr_nxt;
    logic                  w_fill;

    assign w_lu_idx   = if_addr_in[INDEX_BITS+1:2];
    assign w_lu_tag   = if_addr_in[17:INDEX_BITS+2];
    assign w_lu_io    = (if_addr_in[17:16] == 2'b11);
    assign w_fill_idx = r_mem_addr[INDEX_BITS+1:2];
    assign w_fill_tag = r_mem_addr[17:INDEX_BITS+2];
    assign w_fill_io  = (r_mem_addr[17:16] == 2'b11);
    assign w_unused   = ^if_addr_in[1:0];

    // A request still held during its own response pulse must not be served twice.
    assign w_req = if_req_in && !r_inst_valid;
    assign w_hit = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag) && !w_lu_io;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
        end else if (rdy_in) begin
            r_state  <= w_state_nxt;
            r_cancel <= w_cancel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req && !flush_in && !w_hit) w_state_nxt = S_MISS;
            S_MISS:  if (mem_done_in) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cancel_nxt   = r_cancel;
        w_valid_nxt    = 1'b0;
        w_inst_nxt     = r_inst;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_fill         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && !flush_in) begin
                    if (w_hit) begin
                        w_inst_nxt  = r_data[w_lu_idx];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_mem_req_nxt  = 1'b1;
                        w_mem_addr_nxt = {if_addr_in[31:2], 2'b00};
                    end
                end
            end
            S_MISS: begin
                // A flush cannot abort the memory transaction; it only hides the result.
                if (flush_in) w_cancel_nxt = 1'b1;
                if (mem_done_in) begin
                    w_inst_nxt    = mem_data_in;
                    w_mem_req_nxt = 1'b0;
                    w_fill        = !w_fill_io;
                end
            end
            S_DONE: begin
                w_valid_nxt  = !r_cancel && !flush_in;
                w_cancel_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid      <= '0;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'd0;
        end else if (rdy_in) begin
            if (w_fill) r_valid[w_fill_idx] <= 1'b1;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_valid_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_data_in;
        end
    end

    assign inst_out       = r_inst;
    assign inst_valid_out = r_inst_valid;
    assign mem_req_out    = r_mem_req;
    assign mem_addr_out   = r_mem_addr;
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized bench for icache against a line-table model of the cache
module tb_icache;
    localparam int LINES = 128;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = 32'd0;
    logic [31:0] inst_out;
    logic        inst_valid_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_done_in = 1'b0;
    logic [31:0] mem_data_in = 32'd0;

    icache #(.INDEX_BITS(7)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .inst_out(inst_out), .inst_valid_out(inst_valid_out),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_done_in(mem_done_in), .mem_data_in(mem_data_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which word each line holds, indexed by addr bits [8:2], tagged by [17:9].
    bit          m_valid [LINES];
    logic [8:0]  m_tag   [LINES];
    logic [31:0] m_data  [LINES];

    bit          chk_en = 1'b0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_inst = 32'd0;
    bit          exp_req = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    bit          saw_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'd0) return 32'h0000_0013;
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("inst_valid_out", {31'd0, inst_valid_out}, {31'd0, exp_valid});
            if (exp_valid) chk("inst_out", inst_out, exp_inst);
            chk("mem_req_out", {31'd0, mem_req_out}, {31'd0, exp_req});
            if (exp_req) chk("mem_addr_out", mem_addr_out, exp_addr);
        end
        if (mem_req_out) saw_req = 1'b1;
    end

    task automatic cyc(input bit v, input logic [31:0] i, input bit r, input logic [31:0] a);
        @(posedge clk_in);
        #1;
        exp_valid = v;
        exp_inst  = i;
        exp_req   = r;
        exp_addr  = a;
    endtask

    task automatic clear_model();
        for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
    endtask

    // flush_at / frz_at count MISS-state edges from 0; lat is the last of them (done edge),
    // and lat+1 is the edge taken in the response-state cycle.
    task automatic fetch(input logic [31:0] a, input int lat, input int flush_at,
                         input int frz_at, input int frz_len, output bit was_miss);
        int          idx;
        bit          io;
        bit          hit;
        bit          cancel;
        logic [31:0] w;
        logic [31:0] ad;
        idx    = int'(a[8:2]);
        io     = (a[17:16] == 2'b11);
        hit    = m_valid[idx] && (m_tag[idx] == a[17:9]) && !io;
        w      = mem_word(a);
        ad     = {a[31:2], 2'b00};
        cancel = (flush_at >= 0) && (flush_at <= lat + 1);
        saw_req = 1'b0;
        if_req_in  = 1'b1;
        if_addr_in = a;
        if (hit) begin
            was_miss = 1'b0;
            cyc(1'b1, m_data[idx], 1'b0, 32'd0);
            if_req_in = 1'b0;
            if (frz_len > 0) begin
                rdy_in = 1'b0;
                repeat (frz_len) cyc(1'b1, m_data[idx], 1'b0, 32'd0);
                rdy_in = 1'b1;
            end
            cyc(1'b0, 32'd0, 1'b0, 32'd0);
        end else begin
            was_miss = 1'b1;
            cyc(1'b0, 32'd0, 1'b1, ad);
            for (int i = 0; i <= lat + 1; i++) begin
                if (i == frz_at && i <= lat && frz_len > 0) begin
                    rdy_in = 1'b0;
                    repeat (frz_len) cyc(1'b0, 32'd0, 1'b1, ad);
                    rdy_in = 1'b1;
                end
                flush_in = (i == flush_at);
                if (i == lat) begin
                    mem_done_in = 1'b1;
                    mem_data_in = w;
                end
                if (i < lat)       cyc(1'b0, 32'd0, 1'b1, ad);
                else if (i == lat) cyc(1'b0, 32'd0, 1'b0, 32'd0);
                else               cyc(!cancel, w, 1'b0, 32'd0);
                mem_done_in = 1'b0;
                mem_data_in = $urandom;
                flush_in    = 1'b0;
            end
            if_req_in = 1'b0;
            if (!io) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = a[17:9];
                m_data[idx]  = w;
            end
            cyc(1'b0, 32'd0, 1'b0, 32'd0);
        end
    endtask

    task automatic fetch_flushed(input logic [31:0] a);
        if_req_in  = 1'b1;
        if_addr_in = a;
        flush_in   = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 32'd0);
        if_req_in = 1'b0;
        flush_in  = 1'b0;
        cyc(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        saw_req    = 1'b0;
        if_req_in  = 1'b1;
        if_addr_in = a;
        cyc(1'b0, 32'd0, 1'b1, {a[31:2], 2'b00});
        cyc(1'b0, 32'd0, 1'b1, {a[31:2], 2'b00});
        rst_in    = 1'b1;
        if_req_in = 1'b0;
        cyc(1'b0, 32'd0, 1'b0, 32'd0);
        chk("rst_mid_inst_out", inst_out, 32'd0);
        chk("rst_mid_mem_addr", mem_addr_out, 32'd0);
        rst_in = 1'b0;
        clear_model();
        cyc(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        bit          m;
        logic [31:0] a;
        int          lat, fl, fa, flen;
        clear_model();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_inst_out", inst_out, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid_out}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_out}, 32'd0);
        chk("rst_mem_addr", mem_addr_out, 32'd0);
        rst_in = 1'b0;
        cyc(1'b0, 32'd0, 1'b0, 32'd0);
        chk_en = 1'b1;

        fetch(32'h0, 8, -1, -1, 0, m);
        chk("cold_miss", {31'd0, m}, 32'd1);
        chk("cold_req_seen", {31'd0, saw_req}, 32'd1);
        chk("cold_inst", inst_out, 32'h0000_0013);

        fetch(32'h0, 0, -1, -1, 0, m);
        chk("hit_pred", {31'd0, m}, 32'd0);
        chk("hit_no_req", {31'd0, saw_req}, 32'd0);
        chk("hit_inst", inst_out, 32'h0000_0013);

        fetch(32'h200, 3, -1, -1, 0, m);
        chk("conflict_req", {31'd0, saw_req}, 32'd1);
        fetch(32'h0, 2, -1, -1, 0, m);
        chk("conflict_refetch_req", {31'd0, saw_req}, 32'd1);
        chk("conflict_refetch_inst", inst_out, 32'h0000_0013);

        fetch(32'h100, 4, 2, -1, 0, m);
        fetch(32'h100, 0, -1, -1, 0, m);
        chk("flushed_line_hits", {31'd0, saw_req}, 32'd0);
        fetch(32'h104, 3, 4, -1, 0, m);
        fetch(32'h108, 3, 3, -1, 0, m);
        fetch(32'h10C, 3, 0, -1, 0, m);
        fetch_flushed(32'h110);

        fetch(32'h40, 5, -1, 2, 5, m);
        fetch(32'h40, 0, -1, -1, 5, m);
        chk("freeze_hit_no_req", {31'd0, saw_req}, 32'd0);

        fetch(32'h30000, 2, -1, -1, 0, m);
        chk("io_req1", {31'd0, saw_req}, 32'd1);
        fetch(32'h30000, 1, -1, -1, 0, m);
        chk("io_req2", {31'd0, saw_req}, 32'd1);

        reset_mid_miss(32'h400);
        fetch(32'h0, 2, -1, -1, 0, m);
        chk("post_rst_req", {31'd0, saw_req}, 32'd1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h0003_0000 | (32'($urandom_range(0, 7)) << 2);
            end else begin
                a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
                    | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a[31:18] = 14'($urandom);
            end
            lat  = $urandom_range(0, 6);
            fl   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat + 1) : -1;
            fa   = $urandom_range(0, lat);
            flen = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            if ($urandom_range(0, 15) == 0) fetch_flushed(a);
            else fetch(a, lat, fl, fa, flen, m);
            repeat ($urandom_range(0, 2)) cyc(1'b0, 32'd0, 1'b0, 32'd0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the IF stage and the memory controller. Serves IF word fetches in one cycle on a hit. On a miss, issues a single word request to the memory controller, fills the line and returns the word. Cuts the multi-cycle byte-serial fetch cost on loops and removes IF traffic from the shared memory port, so MEM-stage loads and stores win arbitration more often.

## Interface
- INDEX_BITS, 7, index width; 2^INDEX_BITS one-word lines.
- TAG_BITS, 16-INDEX_BITS, tag width; tag = addr[17:INDEX_BITS+2].

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global ready; low freezes all state and holds all outputs.
- flush_in  input  1  branch/jump taken; cancels the current IF request.
- if_req_in  input  1  IF fetch request; held until inst_valid_out.
- if_addr_in  input  32  fetch address; bits [1:0] ignored.
- inst_out  output  32  fetched instruction word.
- inst_valid_out  output  1  one-cycle pulse; inst_out valid this cycle.
- mem_req_out  output  1  word read request to the memory controller.
- mem_addr_out  output  32  request address, {if_addr_in[31:2], 2'b00}.
- mem_done_in  input  1  one-cycle pulse; mem_data_in valid.
- mem_data_in  input  32  little-endian word from the memory controller.

## Operation
- Storage per line: valid bit, TAG_BITS tag, 32-bit data. Valid bits are cleared by reset. Data and tag arrays are not reset.
- State machine: IDLE, MISS, DONE.

IDLE:
- No request: stay in IDLE.
- Request with flush_in=1: request is ignored; stay in IDLE.
- Hit (valid & tag match & addr[17:16]!=2'b11): register the line data into inst_out, pulse inst_valid_out next cycle, stay in IDLE.
- Miss: latch the address, assert mem_req_out, go to MISS.

MISS:
- Hold mem_req_out and mem_addr_out until mem_done_in.
- On mem_done_in:
  - write the line (valid=1, tag, data), except for IO addresses (addr[17:16]==2'b11): no fill, bypass only;
  - drive inst_out=mem_data_in;
  - go to DONE.
- If flush_in is seen at any point in MISS, set a cancel flag. The memory transaction is not aborted; the line is still filled.

DONE:
- Pulse inst_valid_out unless the cancel flag is set.
- Clear the cancel flag and return to IDLE.

Other rules:
- if_req_in in MISS or DONE is not re-evaluated. IF holds its request; after returning to IDLE a same-address request hits.
- flush_in in DONE suppresses the pulse, same as the cancel flag.
- Hit and fill never collide: fill happens only in MISS, lookup only in IDLE.
- rdy_in low: no state, array or output register changes. mem_done_in arriving while rdy_in is low is outside the protocol; the memory controller is frozen by the same rdy_in.

## Timing
- Reset values:
  - inst_out=0, inst_valid_out=0
  - mem_req_out=0, mem_addr_out=0
  - state=IDLE, cancel=0, all valid bits 0.
- Reset asserted mid-MISS: next cycle is IDLE with mem_req_out=0. The lines stay invalid.
- Hit latency: request sampled at edge t gives inst_valid_out high in the cycle after edge t (1 cycle).
- Miss latency: mem_req_out rises the cycle after the request is sampled. With mem_done_in at edge d, inst_valid_out is high in the cycle after edge d+1.
- mem_req_out deasserts in the cycle after mem_done_in is sampled.
- inst_valid_out is never high for two consecutive cycles.
- inst_out holds its last value when inst_valid_out=0.

## Test plan
- Cold miss: reset, fetch 0x00000000, memory returns 0x00000013 after 8 cycles:
  - mem_req_out=1 with mem_addr_out=0x0 until done;
  - inst_valid_out pulses once with inst_out=0x00000013.
- Hit: refetch 0x0 → inst_valid_out 1 cycle after the request, mem_req_out stays 0.
- Conflict: with INDEX_BITS=7, fetch 0x0 then 0x200 (same index, different tag) → 0x200 misses. A third fetch of 0x0 misses again and refetches.
- Flush mid-miss: flush_in for 1 cycle during MISS on 0x100 → no inst_valid_out pulse. A later fetch of 0x100 hits with the filled data.
- Freeze: rdy_in=0 for 5 cycles during MISS and on a hit-response cycle → outputs and state unchanged; the sequence resumes exactly when rdy_in=1.
- IO bypass and reset: fetch 0x30000 → memory is requested every time, with no fill (the second fetch also misses). Reset mid-miss → mem_req_out=0 and valid bits cleared, so 0x0 misses again.
